// File: rtl/uart_arb_pkg.sv
// Shared constants and FSM encoding for the uart_tx round-robin arbiter.
package uart_arb_pkg;

   localparam int unsigned UART_BYTE_W = 8;

   localparam logic [1:0] ST_ARB       = 2'd0;
   localparam logic [1:0] ST_ISSUE     = 2'd1;
   localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
   localparam logic [1:0] ST_WAIT_DONE = 2'd3;

   typedef enum logic [1:0] {
      StArb      = ST_ARB,
      StIssue    = ST_ISSUE,
      StWaitBusy = ST_WAIT_BUSY,
      StWaitDone = ST_WAIT_DONE
   } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module rr_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned GNT_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [GNT_W-1:0] ptr_i,
   output logic             hit_o,
   output logic [GNT_W-1:0] idx_o
);

   logic [GNT_W-1:0] k;

   always_comb begin
      hit_o = 1'b0;
      idx_o = '0;
      k     = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         k = GNT_W'((32'(ptr_i) + i) % N_REQ);
         if (!hit_o && req_i[k]) begin
            hit_o = 1'b1;
            idx_o = k;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one uart_tx among N_REQ byte streams.
// Define UART_ARB_LOCK_TIMEOUT_EN to release a stalled lock after LOCK_TIMEOUT cycles.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned N_REQ        = 4,
   parameter int unsigned GNT_W        = $clog2(N_REQ),
   parameter int unsigned LOCK_TIMEOUT = 1024
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic [N_REQ-1:0]             req_valid_i,
   input  logic [UART_BYTE_W*N_REQ-1:0] req_data_i,
   input  logic [N_REQ-1:0]             req_last_i,
   output logic [N_REQ-1:0]             req_ready_o,
   output logic                         tx_e_o,
   output logic [UART_BYTE_W-1:0]       tx_d_o,
   input  logic                         tx_busy_i,
   input  logic                         tx_done_i,
   output logic [N_REQ-1:0]             grant_o,
   output logic                         active_o,
   output logic                         lock_err_o
);

   if (N_REQ < 2 || N_REQ > 8 || LOCK_TIMEOUT < 1) begin : g_param_check
      $error("uart_tx_arbiter: illegal N_REQ or LOCK_TIMEOUT");
   end

   arb_state_e             state_q, state_d;
   logic [GNT_W-1:0]       gnt_q, gnt_d;
   logic [GNT_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic                   lock_q, lock_d;
   logic                   last_q, last_d;
   logic                   pick_hit;
   logic [GNT_W-1:0]       pick_idx;
   logic [GNT_W-1:0]       gnt_next;
   logic                   sel_valid, sel_last;
   logic [UART_BYTE_W-1:0] sel_data;

`ifdef UART_ARB_LOCK_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(LOCK_TIMEOUT + 1);
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

   rr_pick #(
      .N_REQ (N_REQ),
      .GNT_W (GNT_W)
   ) u_rr_pick (
      .req_i (req_valid_i),
      .ptr_i (rr_ptr_q),
      .hit_o (pick_hit),
      .idx_o (pick_idx)
   );

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (gnt_q == GNT_W'(k)) begin
            sel_valid = req_valid_i[k];
            sel_last  = req_last_i[k];
            sel_data  = req_data_i[k*UART_BYTE_W +: UART_BYTE_W];
         end
      end
   end

   assign gnt_next = (gnt_q == GNT_W'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
   assign active_o = lock_q;

   always_comb begin
      grant_o = '0;
      if (state_q != StArb) grant_o[gnt_q] = 1'b1;
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      rr_ptr_d    = rr_ptr_q;
      lock_d      = lock_q;
      last_d      = last_q;
      tx_e_o      = 1'b0;
      tx_d_o      = '0;
      req_ready_o = '0;
      lock_err_o  = 1'b0;
`ifdef UART_ARB_LOCK_TIMEOUT_EN
      to_cnt_d    = '0;
`endif
      unique case (state_q)
         StArb: begin
            if (pick_hit) begin
               gnt_d   = pick_idx;
               lock_d  = 1'b1;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (sel_valid && tx_done_i && !tx_busy_i) begin
               tx_e_o             = 1'b1;
               tx_d_o             = sel_data;
               req_ready_o[gnt_q] = 1'b1;
               last_d             = sel_last;
               state_d            = StWaitBusy;
            end
`ifdef UART_ARB_LOCK_TIMEOUT_EN
            // Owner went quiet mid-packet: count stall cycles, give up at the limit.
            else if (!sel_valid) begin
               if (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1)) begin
                  lock_err_o = 1'b1;
                  lock_d     = 1'b0;
                  rr_ptr_d   = gnt_next;
                  state_d    = StArb;
               end else begin
                  to_cnt_d = to_cnt_q + 1'b1;
               end
            end
`endif
         end
         // Hold off until uart_tx has left IDLE so one enable yields one frame.
         StWaitBusy: begin
            if (tx_busy_i) state_d = StWaitDone;
         end
         StWaitDone: begin
            if (tx_done_i) begin
               if (last_q) begin
                  lock_d   = 1'b0;
                  rr_ptr_d = gnt_next;
                  state_d  = StArb;
               end else begin
                  state_d  = StIssue;
               end
            end
         end
         default: state_d = StArb;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= StArb;
         gnt_q    <= '0;
         rr_ptr_q <= '0;
         lock_q   <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         rr_ptr_q <= rr_ptr_d;
         lock_q   <= lock_d;
         last_q   <= last_d;
      end
   end

`ifdef UART_ARB_LOCK_TIMEOUT_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) to_cnt_q <= '0;
      else         to_cnt_q <= to_cnt_d;
   end
`endif

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx serializer between N_REQ byte-stream requesters using round-robin arbitration with packet locking. A granted requester keeps the transmitter until it sends a byte flagged last. The block drives the serializer's enable/data inputs and sequences on its busy/done outputs. It sits between the host-side message sources and the single UART TX pin.

Parameters:
N_REQ, 4, number of requesters; legal range 2..8.
GNT_W, $clog2(N_REQ), width of the grant index. Derived; do not override.
LOCK_TIMEOUT, 1024, idle cycles tolerated mid-packet. Used only with UART_ARB_LOCK_TIMEOUT_EN.

Ports:
clk  in  1  system clock
resetn  in  1  reset; asynchronous assert, active-low
req_valid_i  in  N_REQ  per-requester byte valid
req_data_i  in  8*N_REQ  byte of requester k on bits [8k+7:8k]
req_last_i  in  N_REQ  byte is the last of its packet
req_ready_o  out  N_REQ  one-hot accept pulse; byte consumed this cycle
tx_e_o  out  1  enable pulse to uart_tx
tx_d_o  out  8  byte to uart_tx
tx_busy_i  in  1  uart_tx busy
tx_done_i  in  1  uart_tx idle/done level (high in its IDLE)
grant_o  out  N_REQ  one-hot current owner; 0 when no owner
active_o  out  1  packet in progress (lock held)
lock_err_o  out  1  lock-timeout pulse (feature only; tied 0 otherwise)

Behaviour:
- Reset (async, resetn=0): state=ARB, rr_ptr=0, grant index=0, lock=0. Outputs: req_ready_o=0, tx_e_o=0, tx_d_o=8'h00, grant_o=0, active_o=0, lock_err_o=0.
- States: ARB, ISSUE, WAIT_BUSY, WAIT_DONE.
- ARB: search req_valid_i from rr_ptr upward, wrapping modulo N_REQ. On a hit g: register g, set lock=1, go to ISSUE. With no valid request, stay in ARB.
- ISSUE: fire when req_valid_i[g] & tx_done_i & !tx_busy_i. Firing is combinational in that cycle:
  - tx_e_o=1, tx_d_o=req_data_i[g], req_ready_o[g]=1.
  - Register last_seen=req_last_i[g], then go to WAIT_BUSY.
- tx_d_o is 8'h00 whenever tx_e_o=0.
- req_ready_o is never asserted without tx_e_o.
- Exactly one byte is accepted per tx_e_o pulse.
- WAIT_BUSY: wait for tx_busy_i=1, then go to WAIT_DONE. This prevents a second issue before uart_tx leaves IDLE.
- WAIT_DONE: wait for tx_done_i=1.
  - If last_seen=1: lock=0, rr_ptr=(g+1) mod N_REQ, go to ARB.
  - Otherwise go to ISSUE, keeping grant g.
- Mid-packet valid drop (ISSUE, lock=1, req_valid_i[g]=0): hold in ISSUE and keep the grant. Other requesters are ignored.
- grant_o=onehot(g) in ISSUE, WAIT_BUSY and WAIT_DONE; 0 in ARB. active_o mirrors lock.
- Latency: from request valid in ARB to the tx_e_o pulse is 1 cycle if uart_tx is idle. The inter-byte gap within a packet is 1 cycle after tx_done_i rises.
- Single-byte packet (last=1 on the first byte): the lock is released after that byte.
- Simultaneous requests: the winner is the first valid index at or above rr_ptr.
- Requesters must hold valid/data/last stable until ready. A change while waiting is not protected.
- resetn shares its source with uart_tx. Reset mid-byte aborts both blocks; the arbiter returns to ARB with rr_ptr=0.

Optional Feature:
UART_ARB_LOCK_TIMEOUT_EN
- Defined:
  - A counter runs while in ISSUE with lock=1 and req_valid_i[g]=0, and clears whenever valid is high.
  - When the counter reaches LOCK_TIMEOUT: pulse lock_err_o for 1 cycle, set lock=0, rr_ptr=(g+1) mod N_REQ, go to ARB.
- Undefined: no counter; the lock is held indefinitely; lock_err_o=0.

Decomposition:
- Package uart_arb_pkg:
  - state localparams ST_ARB, ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_DONE (2-bit);
  - byte width constant UART_BYTE_W=8.
- Sub-module rr_pick (combinational):
  - inputs req vector and rr_ptr;
  - outputs hit and index (GNT_W);
  - instantiated once in ARB.

Test Plan:
1. Requester 1 only sends 3 bytes 0x41,0x42,0x43 (last on 0x43) against a real uart_tx with CLKS_PER_BIT=20 -> three tx_e_o pulses, each 1 cycle after tx_done_i rises; serial frames decode to 0x41,0x42,0x43; grant_o=4'b0010 throughout; active_o falls after the third frame.
2. Requesters 0 and 2 both request single-byte packets 0xA0/0xA2 from reset -> 0xA0 is sent first, then 0xA2, then ptr=3. A new req0 and req3 pair -> req3 wins.
3. Requester 0 sends a 2-byte packet while requester 1 is valid throughout -> both req0 bytes are sent before any req1 byte; req_ready_o[1]=0 until grant changes.
4. Requester 2 drops valid for 500 cycles mid-packet -> grant is held and no tx_e_o fires. With the feature defined and LOCK_TIMEOUT=64: lock_err_o pulses at cycle 64 and requester 3 is then granted.
5. Assert resetn=0 during the DATA bits of a byte -> asynchronously, all outputs reach reset values and grant_o=0. After release, a new request from req1 is sent cleanly.
